pc_unit: RTL
============

Name: pc_unit

Overview:
Parametrised program-counter unit for the ARMv8 fetch stage, replacing the single-purpose PC register.
- Generates the fetch address with a valid/ready handshake toward instruction memory.
- Supports stall/back-pressure, branch redirect, exception vectoring, halt/resume and misaligned-target faulting.
- Sits between the branch/exception logic and the instruction-memory port; seq_pc_o feeds link-register writeback (BL/BLR).

Parameters:
ADDR_W, 64, PC/address width in bits
INC, 4, bytes added per sequential fetch
ALIGN_BITS, 2, low target bits that must be zero
RESET_VECTOR, 64'h0, PC value loaded on reset (ADDR_W bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall_i  in  1  pipeline stall, hold PC
redirect_i  in  1  branch taken, load redirect_pc_i
redirect_pc_i  in  ADDR_W  branch target
exc_i  in  1  exception/interrupt entry
exc_vec_i  in  ADDR_W  exception vector address
halt_i  in  1  request halt (e.g. HLT/WFI)
fetch_ready_i  in  1  instruction memory accepts pc_o this cycle
pc_o  out  ADDR_W  current fetch address
pc_valid_o  out  1  pc_o is a valid fetch request
seq_pc_o  out  ADDR_W  pc_o + INC, combinational
align_fault_o  out  1  sticky misaligned-target flag
state_o  out  2  FSM state (00 RESET, 01 RUN, 10 HALT, 11 FAULT)

Behaviour:
- Reset (rst=0, asynchronous): pc_o=RESET_VECTOR, pc_valid_o=0, align_fault_o=0, state=RESET. A reset mid-operation aborts everything immediately.
- RESET: on the first clock edge with rst=1, go to RUN; PC unchanged. Fetch of RESET_VECTOR is therefore presented one cycle after reset release.
- pc_valid_o=1 only in RUN. It is a registered state decode, so there is no combinational path from inputs.
- RUN, per-edge priority (highest first):
  1. exc_i: pc<=exc_vec_i with low ALIGN_BITS forced to 0; stay RUN.
  2. redirect_i: if redirect_pc_i[ALIGN_BITS-1:0]==0, pc<=redirect_pc_i and stay RUN; otherwise pc unchanged, align_fault_o<=1, go to FAULT.
  3. halt_i: pc unchanged, go to HALT.
  4. stall_i=1 or fetch_ready_i=0: hold pc.
  5. Otherwise (handshake complete): pc<=pc+INC.
- Redirect/exception override an unaccepted fetch. The pending address is discarded with no handshake needed, and the new address is presented next cycle.
- Redirect/exception are taken even when stall_i=1 (control flow beats stall).
- HALT: pc held, pc_valid_o=0.
  - exc_i: apply rule 1, go to RUN.
  - redirect_i with an aligned target: load it, go to RUN.
  - Misaligned redirect: go to FAULT.
  - halt_i is ignored.
- FAULT: pc held, pc_valid_o=0, align_fault_o=1. Only exc_i (rule 1) exits to RUN and clears align_fault_o; redirect_i and halt_i are ignored.
- Arithmetic is modulo 2^ADDR_W. pc=2^ADDR_W-INC advances to 0 and seq_pc_o wraps identically.
- seq_pc_o = pc_o+INC in every state.

Decomposition:
- Shared package (defines): state encodings (RESET/RUN/HALT/FAULT), active-low reset level constant, default INC and ALIGN_BITS.
- One natural sub-module, pc_next_sel: a combinational priority mux producing next_pc, next_state and fault_set from the inputs and current state.
- pc_unit keeps only the registers and output decode.

Test Plan:
1. Reset release, fetch_ready_i=1, no events -> cycle 0: pc_o=0x0, valid=0; cycle 1: valid=1, pc=0x0; subsequent edges give 0x4, 0x8, 0xC.
2. RUN at pc=0x100, fetch_ready_i=0 for 3 cycles then 1 -> pc stays 0x100 for 3 cycles, then 0x104. Repeat with stall_i=1: identical hold.
3. pc=0x200, redirect_i=1, redirect_pc_i=0x1000, stall_i=1 together -> next pc=0x1000. Same cycle with exc_i=1, exc_vec_i=0x803 -> next pc=0x800 (exception wins, low bits cleared).
4. redirect_pc_i=0x1002 -> pc unchanged, align_fault_o=1, state=11, valid=0. redirect_i to 0x2000 is ignored. exc_i with vec 0x400 -> pc=0x400, fault=0, state=01.
5. halt_i at pc=0x40 -> state=10, valid=0, pc=0x40 held 5 cycles. redirect_i to 0x80 -> state=01, pc=0x80.
6. ADDR_W=64, pc=0xFFFF_FFFF_FFFF_FFFC, seq_pc_o=0x0, handshake completes -> pc=0x0. Assert rst=0 mid-stall -> pc_o=RESET_VECTOR and valid=0 immediately, before the next clock.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared definitions for the fetch-stage program-counter unit.
// Holds the FSM state encoding, the reset level and the default geometry
// of sequential fetch and target alignment.
package pc_unit_pkg;

  // FSM state encoding; the numeric values are visible on state_o.
  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } pc_state_e;

  // Level of rst that holds the unit in reset.
  localparam logic RST_ACTIVE = 1'b0;

  // Default bytes per sequential fetch (one A64 instruction).
  localparam int DEFAULT_INC = 4;

  // Default number of low target bits that must be zero.
  localparam int DEFAULT_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_unit_next_sel.sv
// pc_next_sel: combinational priority mux for the program counter.
// From the current state and the control inputs it selects the next PC,
// the next FSM state and the set/clear requests for the sticky fault flag.
// Priority in RUN: exception, redirect, halt, hold (stall or no handshake),
// sequential advance.
module pc_next_sel
  import pc_unit_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int INC        = DEFAULT_INC,
  parameter int ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
  input  logic [1:0]        state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              exc_i,
  input  logic [ADDR_W-1:0] exc_vec_i,
  input  logic              halt_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] next_pc,
  output logic [1:0]        next_state,
  output logic              fault_set,
  output logic              fault_clr
);

  // Ones in the bit positions that must be zero for a legal target.
  // With ALIGN_BITS=0 the mask is empty and every target is legal.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);

  // Sequential increment at full address width so the add wraps modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  pc_state_e         cur;
  pc_state_e         nxt;
  logic [ADDR_W-1:0] exc_target;
  logic              redirect_ok;

  assign cur         = pc_state_e'(state);
  assign exc_target  = exc_vec_i & ~ALIGN_MASK;
  assign redirect_ok = (redirect_pc_i & ALIGN_MASK) == '0;
  assign next_state  = nxt;

  // Next-state and next-PC selection; each state lists its exits in priority order.
  always_comb begin
    next_pc   = pc;
    nxt       = cur;
    fault_set = 1'b0;
    fault_clr = 1'b0;
    case (cur)
      ST_RESET: begin
        nxt = ST_RUN;
      end
      ST_RUN: begin
        if (exc_i) begin
          next_pc = exc_target;
        end else if (redirect_i) begin
          if (redirect_ok) begin
            next_pc = redirect_pc_i;
          end else begin
            fault_set = 1'b1;
            nxt       = ST_FAULT;
          end
        end else if (halt_i) begin
          nxt = ST_HALT;
        end else if (!stall_i && fetch_ready_i) begin
          next_pc = pc + INC_V;
        end
      end
      ST_HALT: begin
        if (exc_i) begin
          next_pc = exc_target;
          nxt     = ST_RUN;
        end else if (redirect_i) begin
          if (redirect_ok) begin
            next_pc = redirect_pc_i;
            nxt     = ST_RUN;
          end else begin
            fault_set = 1'b1;
            nxt       = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (exc_i) begin
          next_pc   = exc_target;
          nxt       = ST_RUN;
          fault_clr = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register for the fetch stage.
// Holds the PC, the FSM state and the sticky misaligned-target flag, and
// decodes the fetch handshake outputs. All next-value selection lives in
// pc_next_sel. pc_valid_o is decoded from the state register only, so no
// input reaches it combinationally.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                ADDR_W       = 64,
  parameter int                INC          = DEFAULT_INC,
  parameter int                ALIGN_BITS   = DEFAULT_ALIGN_BITS,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              exc_i,
  input  logic [ADDR_W-1:0] exc_vec_i,
  input  logic              halt_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic [ADDR_W-1:0] seq_pc_o,
  output logic              align_fault_o,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  logic [ADDR_W-1:0] pc_q;
  pc_state_e         state_q;
  logic              fault_q;

  logic [ADDR_W-1:0] next_pc;
  logic [1:0]        next_state;
  logic              fault_set;
  logic              fault_clr;

  pc_next_sel #(
    .ADDR_W    (ADDR_W),
    .INC       (INC),
    .ALIGN_BITS(ALIGN_BITS)
  ) u_next_sel (
    .state        (state_q),
    .pc           (pc_q),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .exc_i        (exc_i),
    .exc_vec_i    (exc_vec_i),
    .halt_i       (halt_i),
    .fetch_ready_i(fetch_ready_i),
    .next_pc      (next_pc),
    .next_state   (next_state),
    .fault_set    (fault_set),
    .fault_clr    (fault_clr)
  );

  // State register: PC, FSM state and sticky fault flag; reset aborts at once.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_RESET;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= next_pc;
      state_q <= pc_state_e'(next_state);
      fault_q <= (fault_q | fault_set) & ~fault_clr;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    pc_o          = pc_q;
    seq_pc_o      = pc_q + INC_V;
    pc_valid_o    = (state_q == ST_RUN);
    align_fault_o = fault_q;
    state_o       = state_q;
  end

endmodule
